// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM and next-PC selection.
// Define MIPS_FETCH_PERF_CNT_EN to add the saturating o_fetch_cnt counter.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [5:0]        o_op_code,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  input  logic              i_stall,
  input  logic              i_is_jump,
  input  logic              i_is_branch,
  input  logic              i_alu_zero
`ifdef MIPS_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       o_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] branch_off;

  // The request address is the PC itself; it only moves on consumption,
  // so it is stable for the whole REQ period.
  assign o_imem_addr = pc;
  assign o_op_code   = o_instr[31:26];

  // NOTE: every path assigns next_pc, so no latch is inferred.
  always_comb begin
    branch_off = {{14{o_instr[15]}}, o_instr[15:0], 2'b00};
    if (i_is_jump) begin
      next_pc = {o_pc_plus4[31:28], o_instr[25:0], 2'b00};
    end else if (i_is_branch && i_alu_zero) begin
      next_pc = o_pc_plus4 + branch_off;
    end else begin
      next_pc = o_pc_plus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      o_imem_req <= 1'b0;
      o_valid    <= 1'b0;
      o_instr    <= 32'h0000_0000;
      o_pc       <= RESET_PC;
      o_pc_plus4 <= RESET_PC + 32'd4;
    end else begin
      case (state)
        IDLE: begin
          state      <= REQ;
          o_imem_req <= 1'b1;
        end
        REQ: begin
          if (i_imem_ack) begin
            o_instr    <= i_imem_rdata;
            o_pc       <= pc;
            o_pc_plus4 <= pc + 32'd4;
            o_valid    <= 1'b1;
            o_imem_req <= 1'b0;
            state      <= VALID;
          end
        end
        VALID: begin
          // Decision inputs only matter on the consuming edge.
          if (!i_stall) begin
            pc         <= next_pc;
            o_valid    <= 1'b0;
            o_imem_req <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          state      <= IDLE;
          o_imem_req <= 1'b0;
          o_valid    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIPS_FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fetch_cnt <= 32'h0000_0000;
    end else if (state == REQ && i_imem_ack && o_fetch_cnt != 32'hFFFF_FFFF) begin
      o_fetch_cnt <= o_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed PC-flow table, stall and
// reset corner sequences, then random instructions against an arithmetic PC model.
module tb_mips_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [5:0]  o_op_code;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        i_stall;
  logic        i_is_jump;
  logic        i_is_branch;
  logic        i_alu_zero;
`ifdef MIPS_FETCH_PERF_CNT_EN
  logic [31:0] o_fetch_cnt;
`endif

  mips_fetch_stage #(
    .RESET_PC(RESET_PC),
    .ADDR_W  (32)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_rdata(i_imem_rdata),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_op_code   (o_op_code),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4),
    .i_stall     (i_stall),
    .i_is_jump   (i_is_jump),
    .i_is_branch (i_is_branch),
    .i_alu_zero  (i_alu_zero)
`ifdef MIPS_FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt (o_fetch_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_addr;
  int          exp_cnt;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    int          stall_n;
    bit          j;
    bit          b;
    bit          z;
    logic [31:0] pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference PC rule, stated with plain arithmetic on the architectural values.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input bit j, input bit b, input bit z);
    logic [31:0] pc4;
    logic [15:0] imm;
    pc4 = pc + 32'd4;
    imm = instr[15:0];
    if (j) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (b && z) return pc4 + 32'(int'($signed(imm)) * 4);
    return pc4;
  endfunction

  // One full fetch: wait for the request, ack after lat cycles, hold for
  // stall_n cycles, then consume with the given decisions.
  task automatic apply(input logic [31:0] instr, input int lat, input int stall_n,
                       input bit j, input bit b, input bit z,
                       input bit use_tbl, input logic [31:0] tbl_pc, input string tag);
    bit          got;
    logic [31:0] addr_seen;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (o_imem_req) got = 1'b1;
      else @(negedge i_clk);
    end
    check({tag, "_req_seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, "_addr"}, o_imem_addr, exp_addr);
    if (use_tbl) check({tag, "_tbl_addr"}, o_imem_addr, tbl_pc);
    addr_seen = o_imem_addr;
    for (int k = 0; k < lat; k++) begin
      i_imem_ack   = 1'b0;
      i_imem_rdata = $urandom;
      {i_is_jump, i_is_branch, i_alu_zero} = 3'($urandom);
      i_stall      = 1'($urandom);
      @(negedge i_clk);
      check({tag, "_wait_req"}, 32'(o_imem_req), 32'd1);
      check({tag, "_wait_addr"}, o_imem_addr, addr_seen);
      check({tag, "_wait_valid"}, 32'(o_valid), 32'd0);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = instr;
    @(negedge i_clk);
    exp_cnt++;
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_instr"}, o_instr, instr);
    check({tag, "_opcode"}, 32'(o_op_code), 32'(instr >> 26));
    check({tag, "_pc"}, o_pc, exp_addr);
    check({tag, "_pc4"}, o_pc_plus4, exp_addr + 32'd4);
    check({tag, "_req_low"}, 32'(o_imem_req), 32'd0);
    for (int k = 0; k < stall_n; k++) begin
      i_stall     = 1'b1;
      i_is_jump   = j;
      i_is_branch = b;
      i_alu_zero  = z;
      @(negedge i_clk);
      check({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_stall_req"}, 32'(o_imem_req), 32'd0);
      check({tag, "_stall_pc"}, o_pc, exp_addr);
      check({tag, "_stall_instr"}, o_instr, instr);
      check({tag, "_stall_addr"}, o_imem_addr, addr_seen);
    end
    i_stall     = 1'b0;
    i_is_jump   = j;
    i_is_branch = b;
    i_alu_zero  = z;
    @(negedge i_clk);
    exp_addr = model_next(exp_addr, instr, j, b, z);
    check({tag, "_consumed_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_next_req"}, 32'(o_imem_req), 32'd1);
    check({tag, "_next_addr"}, o_imem_addr, exp_addr);
    {i_is_jump, i_is_branch, i_alu_zero} = 3'($urandom);
  endtask

  vec_t tab[13];

  initial begin
    tab[0]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    tab[1]  = '{32'h0000_0000, 5, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0004};
    tab[2]  = '{32'h1000_0003, 1, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0008};
    tab[3]  = '{32'h1000_FFFB, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0018};
    tab[4]  = '{32'h1000_0003, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008};
    tab[5]  = '{32'h1000_FFFB, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_000C};
    tab[6]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tab[7]  = '{32'h0BFF_FFFF, 1, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
    tab[8]  = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC};
    tab[9]  = '{32'h1000_0003, 0, 0, 1'b0, 1'b1, 1'b1, 32'h1000_0000};
    tab[10] = '{32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'h1000_0010};
    tab[11] = '{32'h0800_0080, 0, 4, 1'b1, 1'b0, 1'b0, 32'h1000_0100};
    tab[12] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h1000_0200};

    i_reset      = 1'b0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    i_stall      = 1'b0;
    i_is_jump    = 1'b0;
    i_is_branch  = 1'b0;
    i_alu_zero   = 1'b0;
    exp_addr     = RESET_PC;
    exp_cnt      = 0;
    #12;
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_addr", o_imem_addr, RESET_PC);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", o_pc, RESET_PC);
    check("rst_pc4", o_pc_plus4, RESET_PC + 32'd4);
`ifdef MIPS_FETCH_PERF_CNT_EN
    check("rst_cnt", o_fetch_cnt, 32'd0);
`endif
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("first_req", 32'(o_imem_req), 32'd1);
    check("first_addr", o_imem_addr, RESET_PC);

    for (int i = 0; i < 13; i++) begin
      apply(tab[i].instr, tab[i].lat, tab[i].stall_n, tab[i].j, tab[i].b, tab[i].z,
            1'b1, tab[i].pc, $sformatf("tbl%0d", i));
    end

    // Reset while a request is outstanding, with a late ack landing in IDLE.
    @(negedge i_clk);
    check("mid_req_pending", 32'(o_imem_req), 32'd1);
    #2 i_reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(o_imem_req), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_addr", o_imem_addr, RESET_PC);
    @(negedge i_clk);
    i_reset      = 1'b1;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    check("late_ack_valid", 32'(o_valid), 32'd0);
    check("late_ack_instr", o_instr, 32'h0);
    check("restart_req", 32'(o_imem_req), 32'd1);
    check("restart_addr", o_imem_addr, RESET_PC);
    exp_addr = RESET_PC;
    exp_cnt  = 0;
`ifdef MIPS_FETCH_PERF_CNT_EN
    check("restart_cnt", o_fetch_cnt, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      apply($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 32'h0, $sformatf("rnd%0d", i));
    end
`ifdef MIPS_FETCH_PERF_CNT_EN
    check("final_cnt", o_fetch_cnt, 32'(exp_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS core.
- Holds the PC and fetches instructions through a req/ack instruction-memory port.
- Presents the current instruction and its opcode field to the main control unit.
- Consumes that unit's jump/branch decisions (plus the ALU zero flag) to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
ADDR_W, 32, PC and instruction-memory address width; fixed at 32 for this core.

Ports:
i_clk  in  1  core clock, rising edge.
i_reset  in  1  asynchronous, active-low reset.
o_imem_req  out  1  fetch request to instruction memory.
o_imem_addr  out  32  word-aligned fetch address.
i_imem_ack  in  1  memory returns data this cycle.
i_imem_rdata  in  32  instruction word, valid when i_imem_ack=1.
o_valid  out  1  o_instr/o_pc hold a fetched instruction.
o_instr  out  32  current instruction.
o_op_code  out  6  o_instr[31:26], feeds the control unit's i_op_code.
o_pc  out  32  address of o_instr.
o_pc_plus4  out  32  o_pc + 4.
i_stall  in  1  downstream not ready; hold the current instruction.
i_is_jump  in  1  control unit jump decision for o_instr.
i_is_branch  in  1  control unit branch decision for o_instr.
i_alu_zero  in  1  ALU zero flag (beq compare result).

Behaviour:
- Reset (i_reset=0, async) forces:
  - state=IDLE, pc=RESET_PC
  - o_imem_req=0, o_imem_addr=RESET_PC
  - o_valid=0, o_instr=0, o_pc=RESET_PC, o_pc_plus4=RESET_PC+4
- FSM states: IDLE, REQ, VALID.
- IDLE: first clock after reset release → REQ.
- REQ:
  - o_imem_req=1, o_imem_addr=pc, both held stable until ack.
  - On i_imem_ack=1: o_instr<=i_imem_rdata, o_pc<=pc, o_valid<=1 → VALID.
  - i_imem_rdata is ignored when ack=0.
  - Memory latency is unbounded; no timeout.
- VALID:
  - o_imem_req=0, o_valid=1, all outputs held.
  - i_stall=1 → stay in VALID, nothing changes.
  - i_stall=0 → instruction is consumed at this edge:
    - pc<=next_pc
    - o_valid<=0
    - → REQ, which issues the next request on the following cycle.
- next_pc (computed only on consumption; mod 2^32 arithmetic):
  - i_is_jump=1 → {o_pc_plus4[31:28], o_instr[25:0], 2'b00}.
  - else i_is_branch=1 and i_alu_zero=1 → o_pc_plus4 + (sign_extend(o_instr[15:0]) << 2).
  - else → o_pc_plus4.
- Jump has priority over branch if both are asserted.
- Branch/jump/zero inputs are ignored whenever o_valid=0 or i_stall=1.
- Throughput: one instruction per (memory latency + 2) cycles minimum; with zero-wait memory (ack in the first REQ cycle), 1 instruction per 2 cycles.
- o_op_code is combinational from the o_instr register. The control unit then decodes o_op_code combinationally in the same cycle.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Reset asserted during REQ: o_imem_req drops immediately (async). Memory must tolerate the abandoned request; a late ack arriving in IDLE is ignored.
- i_imem_ack asserted outside REQ is ignored.

Optional Feature:
- Macro: MIPS_FETCH_PERF_CNT_EN.
- Defined:
  - Adds output o_fetch_cnt (32).
  - Increments by 1 on every accepted ack in REQ; saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Undefined:
  - Port and counter logic absent.
  - All other behaviour identical.

Test Plan:
- Reset with RESET_PC=0, release, zero-wait memory returning 32'h0000_0020 (R-type add), i_stall=0 → req at addr 0 on cycle 2; o_valid=1, o_op_code=6'b000000, o_pc=0 on cycle 3; next req addr=4.
- Memory ack delayed 5 cycles → o_imem_addr and o_imem_req stable for all 5 cycles; o_valid stays 0 until the ack edge.
- Instruction 32'h1000_0003 (beq, imm=3) at pc=8, i_is_branch=1, i_alu_zero=1 → next addr=32'h18; same instruction with i_alu_zero=0 → next addr=32'hC.
- Instruction 32'h0800_0040 (j) at pc=32'h1000_0010, i_is_jump=1 → next addr=32'h1000_0100; also assert i_is_branch=1 together → still 32'h1000_0100.
- i_stall=1 for 4 cycles in VALID with i_is_jump=1 → no request, outputs unchanged; on stall release, exactly one redirect to the jump target.
- Assert reset mid-REQ, then ack arrives while in IDLE → o_imem_req=0 immediately, ack ignored, o_valid=0; fetch restarts at RESET_PC (o_fetch_cnt=0 when the feature is enabled).
